// File: rtl/iter_divide.sv
// iter_divide: iterative restoring divider, one quotient bit per enabled clock.
// Handles signed/unsigned operands independently; truncating signed division.
// Optional feature macro: ITER_DIVIDE_REMPOS_EN (forces a nonnegative remainder).
module iter_divide #(
   parameter int unsigned WIDTHN = 16,
   parameter int unsigned WIDTHD = 16
) (
   input  logic              i_clock,
   input  logic              i_aclr,
   input  logic              i_clken,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [WIDTHN-1:0] i_numer,
   input  logic [WIDTHD-1:0] i_denom,
   input  logic              i_nsigned,
   input  logic              i_dsigned,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [WIDTHN-1:0] o_quotient,
   output logic [WIDTHD-1:0] o_remain,
   output logic              o_dbz
);
   localparam int unsigned CNTW = $clog2(WIDTHN + 1);
   localparam int unsigned RW   = WIDTHD + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [WIDTHN-1:0] nmag_q, nmag_d;
   logic [WIDTHD-1:0] rem_q, rem_d;
   logic [WIDTHD-1:0] dmag_q, dmag_d;
   logic [WIDTHD-1:0] nlow_q, nlow_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;
   logic              zero_q, zero_d;
`ifdef ITER_DIVIDE_REMPOS_EN
   logic              dneg_q, dneg_d;
`endif
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [WIDTHN-1:0] quot_q, quot_d;
   logic [WIDTHD-1:0] remo_q, remo_d;
   logic              dbz_q, dbz_d;

   logic              sn_c, sd_c, last_c, ge_c;
   logic [RW-1:0]     shift_c, diff_c;
   logic [WIDTHN-1:0] qbase_c, qfix_c;
   logic [WIDTHD-1:0] rbase_c, rfix_c;

   assign sn_c    = i_nsigned & i_numer[WIDTHN-1];
   assign sd_c    = i_dsigned & i_denom[WIDTHD-1];
   assign last_c  = (cnt_q == CNTW'(WIDTHN));
   assign shift_c = {rem_q, nmag_q[WIDTHN-1]};
   assign ge_c    = (shift_c >= {1'b0, dmag_q});
   assign diff_c  = shift_c - {1'b0, dmag_q};

   assign o_ready    = ready_q;
   assign o_valid    = valid_q;
   assign o_quotient = quot_q;
   assign o_remain   = remo_q;
   assign o_dbz      = dbz_q;

   // Sign correction of the unsigned magnitudes left by the iteration
   always_comb begin
      qbase_c = negq_q ? -nmag_q : nmag_q;
      rbase_c = negr_q ? -rem_q : rem_q;
      qfix_c  = qbase_c;
      rfix_c  = rbase_c;
`ifdef ITER_DIVIDE_REMPOS_EN
      if (negr_q && (rem_q != '0)) begin
         rfix_c = dmag_q - rem_q;
         qfix_c = dneg_q ? (qbase_c + WIDTHN'(1)) : (qbase_c - WIDTHN'(1));
      end
`endif
   end

   // State register plus all datapath/output flops; clock enable freezes everything
   always_ff @(posedge i_clock or posedge i_aclr) begin
      if (i_aclr) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         nmag_q  <= '0;
         rem_q   <= '0;
         dmag_q  <= '0;
         nlow_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         zero_q  <= 1'b0;
`ifdef ITER_DIVIDE_REMPOS_EN
         dneg_q  <= 1'b0;
`endif
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else if (i_clken) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nmag_q  <= nmag_d;
         rem_q   <= rem_d;
         dmag_q  <= dmag_d;
         nlow_q  <= nlow_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         zero_q  <= zero_d;
`ifdef ITER_DIVIDE_REMPOS_EN
         dneg_q  <= dneg_d;
`endif
         ready_q <= ready_d;
         valid_q <= valid_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_valid) state_d = S_CALC;
         S_CALC:  if (last_c) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  if (i_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture, shift-subtract step, result formatting and handshake outputs
   always_comb begin
      cnt_d   = cnt_q;
      nmag_d  = nmag_q;
      rem_d   = rem_q;
      dmag_d  = dmag_q;
      nlow_d  = nlow_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      zero_d  = zero_q;
`ifdef ITER_DIVIDE_REMPOS_EN
      dneg_d  = dneg_q;
`endif
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_DONE);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (i_valid) begin
               nmag_d = sn_c ? -i_numer : i_numer;
               dmag_d = sd_c ? -i_denom : i_denom;
               rem_d  = '0;
               negq_d = sn_c ^ sd_c;
               negr_d = sn_c;
               zero_d = (i_denom == '0);
               nlow_d = i_numer[WIDTHD-1:0];
`ifdef ITER_DIVIDE_REMPOS_EN
               dneg_d = sd_c;
`endif
            end
         end
         S_CALC: begin
            if (!last_c) begin
               rem_d  = WIDTHD'(ge_c ? diff_c : shift_c);
               nmag_d = {nmag_q[WIDTHN-2:0], ge_c};
               cnt_d  = cnt_q + CNTW'(1);
            end
         end
         S_FIX: begin
            if (zero_q) begin
               quot_d = '1;
               remo_d = nlow_q;
               dbz_d  = 1'b1;
            end else begin
               quot_d = qfix_c;
               remo_d = rfix_c;
               dbz_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_iter_divide.sv
// tb_iter_divide: scoreboard bench for iter_divide (WIDTHN=8, WIDTHD=4).
module tb_iter_divide;
   localparam int unsigned WN = 8;
   localparam int unsigned WD = 4;
   localparam int LAT = WN + 2;

   typedef struct packed {
      logic [WN-1:0] q;
      logic [WD-1:0] r;
      logic          z;
   } exp_t;

   logic          clk = 1'b0;
   logic          i_aclr, i_clken, i_valid, i_ready, i_nsigned, i_dsigned;
   logic          o_ready, o_valid, o_dbz;
   logic [WN-1:0] i_numer, o_quotient;
   logic [WD-1:0] i_denom, o_remain;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   en_cnt = 0;
   int   raw_cnt = 0;
   int   acc_en = 0;
   int   acc_raw = 0;
   int   last_raw_lat = 0;

   iter_divide #(.WIDTHN(WN), .WIDTHD(WD)) dut (
      .i_clock(clk), .i_aclr(i_aclr), .i_clken(i_clken),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_numer(i_numer), .i_denom(i_denom),
      .i_nsigned(i_nsigned), .i_dsigned(i_dsigned),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_quotient(o_quotient), .o_remain(o_remain), .o_dbz(o_dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   // Reference: plain integer division, truncating toward zero
   function automatic exp_t ref_div(input logic [WN-1:0] n, input logic [WD-1:0] d,
                                    input bit ns, input bit ds);
      exp_t   e;
      longint nv, dv, qv, rv;
      nv = ns ? longint'($signed(n)) : longint'(n);
      dv = ds ? longint'($signed(d)) : longint'(d);
      if (dv == 0) begin
         e.q = '1;
         e.r = n[WD-1:0];
         e.z = 1'b1;
      end else begin
         qv = nv / dv;
         rv = nv % dv;
`ifdef ITER_DIVIDE_REMPOS_EN
         if (rv < 0) begin
            rv = rv + ((dv < 0) ? -dv : dv);
            qv = qv + ((dv < 0) ? 1 : -1);
         end
`endif
         e.q = WN'(qv);
         e.r = WD'(rv);
         e.z = 1'b0;
      end
      return e;
   endfunction

   // Enabled-edge and raw-edge counters for latency measurement
   always @(posedge clk) begin
      if (!i_aclr) begin
         raw_cnt++;
         if (i_clken) en_cnt++;
      end
   end

   // Monitor: pops the scoreboard on each new result and checks handshake behaviour
   logic          was_valid = 1'b0;
   logic          hs_prev = 1'b0;
   logic [WN-1:0] hq;
   logic [WD-1:0] hr;
   logic          hz;
   always @(negedge clk) begin
      exp_t e;
      if (i_aclr) begin
         was_valid = 1'b0;
         hs_prev   = 1'b0;
      end else begin
         if (hs_prev) begin
            chk("exit_valid", longint'(o_valid), 0);
            chk("exit_ready", longint'(o_ready), 1);
         end
         if (o_valid) begin
            if (!was_valid) begin
               chk("latency", longint'(en_cnt - acc_en), longint'(LAT));
               last_raw_lat = raw_cnt - acc_raw;
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  e = exp_q.pop_front();
                  chk("quotient", longint'(o_quotient), longint'(e.q));
                  chk("remainder", longint'(o_remain), longint'(e.r));
                  chk("dbz", longint'(o_dbz), longint'(e.z));
               end
               hq = o_quotient;
               hr = o_remain;
               hz = o_dbz;
            end else begin
               chk("stable_q", longint'(o_quotient), longint'(hq));
               chk("stable_r", longint'(o_remain), longint'(hr));
               chk("stable_dbz", longint'(o_dbz), longint'(hz));
            end
            chk("ready_in_done", longint'(o_ready), 0);
         end
         if (i_valid && o_ready && i_clken) begin
            acc_en  = en_cnt + 1;
            acc_raw = raw_cnt + 1;
         end
         hs_prev   = o_valid && i_ready && i_clken;
         was_valid = o_valid;
      end
   end

   task automatic issue(input logic [WN-1:0] n, input logic [WD-1:0] d,
                        input bit ns, input bit ds, input exp_t e);
      int t = 0;
      while (!o_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!o_ready) begin
         fail_now("ready_wait");
         return;
      end
      i_numer = n; i_denom = d; i_nsigned = ns; i_dsigned = ds;
      i_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      i_valid   = 1'b0;
      i_numer   = WN'($urandom);
      i_denom   = WD'($urandom);
      i_nsigned = 1'($urandom);
      i_dsigned = 1'($urandom);
   endtask

   task automatic wait_done(input bit rnd);
      int t = 0;
      while (exp_q.size() != 0 || o_valid) begin
         @(posedge clk); #1;
         if (rnd) begin
            i_clken = ($urandom_range(0, 3) != 0);
            i_ready = 1'($urandom_range(0, 1));
            i_valid = !o_ready && ($urandom_range(0, 1) == 1);
            i_numer = WN'($urandom);
            i_denom = WD'($urandom);
         end
         t++;
         if (t > 300) begin
            fail_now("done_wait");
            exp_q.delete();
            break;
         end
      end
      i_clken = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, longint'(o_valid), 0);
      chk({tag, "_ready"}, longint'(o_ready), 1);
      chk({tag, "_q"}, longint'(o_quotient), 0);
      chk({tag, "_r"}, longint'(o_remain), 0);
      chk({tag, "_dbz"}, longint'(o_dbz), 0);
   endtask

   initial begin
      int   t;
      exp_t e;
      logic [WN-1:0] rn;
      logic [WD-1:0] rd;
      bit   rns, rds;
      i_aclr = 1'b1; i_clken = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      i_numer = '0; i_denom = '0; i_nsigned = 1'b0; i_dsigned = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      i_aclr = 1'b0;
      @(posedge clk); #1;

      // Unsigned 200/7
      issue(8'd200, 4'd7, 1'b0, 1'b0, '{q: 8'd28, r: 4'd4, z: 1'b0});
      wait_done(1'b0);
      // Signed -7/2
`ifdef ITER_DIVIDE_REMPOS_EN
      issue(8'hF9, 4'h2, 1'b1, 1'b1, '{q: 8'hFC, r: 4'h1, z: 1'b0});
`else
      issue(8'hF9, 4'h2, 1'b1, 1'b1, '{q: 8'hFD, r: 4'hF, z: 1'b0});
`endif
      wait_done(1'b0);
      // Divide by zero
      issue(8'd77, 4'd0, 1'b0, 1'b0, '{q: 8'hFF, r: 4'hD, z: 1'b1});
      wait_done(1'b0);
      // Most negative / -1 wraps
      issue(8'h80, 4'hF, 1'b1, 1'b1, '{q: 8'h80, r: 4'h0, z: 1'b0});
      wait_done(1'b0);
      // Unsigned interpretation of sign bits when signed inputs are low
      issue(8'hF9, 4'hA, 1'b0, 1'b0, '{q: 8'd24, r: 4'd9, z: 1'b0});
      wait_done(1'b0);

      // Consumer stalls 5 cycles in DONE
      i_ready = 1'b0;
      issue(8'd5, 4'd2, 1'b0, 1'b0, '{q: 8'd2, r: 4'd1, z: 1'b0});
      t = 0;
      while (!o_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!o_valid) fail_now("hold_wait");
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold_valid", longint'(o_valid), 1);
         chk("hold_ready", longint'(o_ready), 0);
      end
      i_ready = 1'b1;
      wait_done(1'b0);

      // Clock enable low 3 cycles mid-CALC stretches latency by 3
      issue(8'd200, 4'd7, 1'b0, 1'b0, '{q: 8'd28, r: 4'd4, z: 1'b0});
      repeat (3) begin @(posedge clk); #1; end
      i_clken = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      i_clken = 1'b1;
      wait_done(1'b0);
      chk("clken_raw_latency", longint'(last_raw_lat), longint'(LAT + 3));

      // Reset pulsed at step 4 of CALC discards the operation
      issue(8'd200, 4'd7, 1'b0, 1'b0, '{q: 8'd28, r: 4'd4, z: 1'b0});
      repeat (4) @(posedge clk);
      #1;
      i_aclr = 1'b1;
      #1;
      exp_q.delete();
      chk_reset_outputs("midcalc_reset");
      i_clken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset_over_clken");
      i_clken = 1'b1;
      i_aclr  = 1'b0;
      @(posedge clk); #1;
      issue(8'd9, 4'd3, 1'b0, 1'b0, '{q: 8'd3, r: 4'd0, z: 1'b0});
      wait_done(1'b0);

      // Randomized operands, signedness and handshake/enable activity
      for (int i = 0; i < 60; i++) begin
         rn  = WN'($urandom);
         rd  = WD'($urandom_range(0, 15));
         rns = 1'($urandom);
         rds = 1'($urandom);
         e   = ref_div(rn, rd, rns, rds);
         issue(rn, rd, rns, rds, e);
         wait_done(1'b1);
      end

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/iter_divide.md
ITER_DIVIDE -- requirements
Module: iter_divide

Interface
REQ-001 SHALL provide parameter WIDTHN, default 16: width of numerator and quotient, legal range 2..64.
REQ-002 SHALL provide parameter WIDTHD, default 16: width of denominator and remainder, legal range 2..WIDTHN.
REQ-003 SHALL provide port i_clock, input, 1: clock, all state changes on rising edge.
REQ-004 SHALL provide port i_aclr, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL provide port i_clken, input, 1: clock enable; low freezes all state and outputs.
REQ-006 SHALL provide port i_valid, input, 1: request valid.
REQ-007 SHALL provide port o_ready, output, 1: divider can accept a request.
REQ-008 SHALL provide port i_numer, input, WIDTHN: numerator.
REQ-009 SHALL provide port i_denom, input, WIDTHD: denominator.
REQ-010 SHALL provide port i_nsigned, input, 1: numerator is two's complement.
REQ-011 SHALL provide port i_dsigned, input, 1: denominator is two's complement.
REQ-012 SHALL provide port o_valid, output, 1: result valid.
REQ-013 SHALL provide port i_ready, input, 1: consumer accepts the result.
REQ-014 SHALL provide port o_quotient, output, WIDTHN: quotient.
REQ-015 SHALL provide port o_remain, output, WIDTHD: remainder.
REQ-016 SHALL provide port o_dbz, output, 1: divide-by-zero flag, qualified by o_valid.

Function
REQ-017 SHALL implement FSM IDLE, CALC, FIX, DONE; o_ready = (state == IDLE); o_valid = (state == DONE).
REQ-018 SHALL accept a request on an enabled edge with i_valid & o_ready; it registers magnitudes |numer| and |denom|, result signs and the zero-denominator flag, then enters CALC.
REQ-019 SHALL perform one restoring shift-subtract step per enabled edge in CALC, WIDTHN steps in total, tracked by a step counter, then enter FIX.
REQ-020 SHALL apply sign correction in FIX and enter DONE one enabled edge later.
REQ-021 SHALL assert o_valid exactly WIDTHN+2 enabled edges after the accept edge, for every operand pair including divide by zero.
REQ-022 SHALL, for signed operation, truncate the quotient toward zero (quotient sign = sign_n XOR sign_d) and give a nonzero remainder the sign of the numerator.
REQ-023 SHALL treat an operand as unsigned when its signed input is low; a sign bit counts only when the corresponding signed input is high.
REQ-024 SHALL produce for signed most-negative / -1 a quotient of most-negative (wrap) and a remainder of 0, with no flag.
REQ-025 SHALL, when denom is zero, give o_quotient all ones, o_remain = the low WIDTHD bits of i_numer, and o_dbz = 1; otherwise o_dbz = 0.
REQ-026 SHALL hold o_quotient, o_remain and o_dbz stable in DONE until i_ready is sampled high, then enter IDLE.
REQ-027 SHALL not accept a new request on the DONE-exit edge; o_ready rises on the following cycle.
REQ-028 SHALL ignore i_valid, i_numer and i_denom outside IDLE; operands captured at accept are used.

Reset
REQ-029 SHALL, on i_aclr high at any time including mid-CALC, force state IDLE, clear the step counter, and drive o_valid=0, o_quotient=0, o_remain=0, o_dbz=0; o_ready=1 while in reset.
REQ-030 SHALL discard any in-flight operation on reset; i_aclr overrides i_clken.

Configuration
REQ-031 SHALL, with ITER_DIVIDE_REMPOS_EN defined, make a negative remainder positive in FIX: add |denom| to the remainder and subtract 1 from the quotient if denom is nonnegative, else add 1; the cycle count is unchanged.
REQ-032 SHALL, with ITER_DIVIDE_REMPOS_EN undefined, omit that logic, so the remainder takes the numerator's sign per REQ-022.

Verification (WIDTHN=8, WIDTHD=4)
REQ-033 SHALL cover unsigned 200/7 -> q=8'd28, r=4'd4, o_dbz=0, o_valid exactly 10 enabled edges after accept.
REQ-034 SHALL cover signed 8'hF9 / 4'h2 -> q=8'hFD, r=4'hF without the macro; q=8'hFC, r=4'h1 with it.
REQ-035 SHALL cover 8'd77 / 4'd0 -> q=8'hFF, r=4'hD, o_dbz=1, same latency as REQ-033.
REQ-036 SHALL cover signed 8'h80 / 4'hF -> q=8'h80, r=4'h0, o_dbz=0.
REQ-037 SHALL cover i_ready held low 5 cycles in DONE -> outputs stable and o_ready=0; i_clken low 3 cycles mid-CALC -> latency grows by exactly 3.
REQ-038 SHALL cover i_aclr pulsed at step 4 of CALC -> all outputs 0, o_ready=1; next request 9/3 -> q=8'd3, r=4'd0.
